m68k_bus_cycle: RTL and testbench

Drives one 68000 asynchronous bus cycle per request, stepping S0..S7 on the single-SYSCLK MCCLK_RISING/MCCLK_FALLING strobes from the clock-synchroniser stage. It consumes that stage's DTACK_LATCH pulse to end wait states. It sits between the host-side request interface and the physical 68000 bus pins.

---
 rtl/m68k_bus_pkg.sv | 29 ++
 rtl/m68k_bus_timeout.sv | 28 ++
 rtl/m68k_bus_cycle.sv | 183 ++++++++++++++++++
 tb/tb_m68k_bus_cycle.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/m68k_bus_pkg.sv
// Shared types and constants for the 68000 bus-cycle engine.
package m68k_bus_pkg;

    typedef enum logic [3:0] {
        IDLE  = 4'd0,
        ARMED = 4'd1,
        S0    = 4'd2,
        S1    = 4'd3,
        S2    = 4'd4,
        S3    = 4'd5,
        S4    = 4'd6,
        S5    = 4'd7,
        S6    = 4'd8,
        S7    = 4'd9
    } bus_state_e;

    localparam logic STROBE_OFF = 1'b1;
    localparam logic RW_READ    = 1'b1;

    localparam int         BE_UDS_BIT = 1;
    localparam int         BE_LDS_BIT = 0;
    localparam logic [1:0] BE_BOTH    = 2'b11;

    // An all-zero enable pattern still has to move a word, so it becomes both lanes.
    function automatic logic [1:0] be_norm(input logic [1:0] be);
        return (be == 2'b00) ? BE_BOTH : be;
    endfunction

endpackage

// File: rtl/m68k_bus_timeout.sv
// S4 wait-state watchdog: counts MC falling strobes spent waiting for DTACK.
// Only instantiated when BUS_TIMEOUT_EN is defined.
module m68k_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_W      = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr_i,
    input  logic en_i,
    output logic expired_o
);

    logic [TIMEOUT_W-1:0] cnt_q;

    always_ff @(negedge clk_i or posedge rst_i) begin
        if (rst_i)
            cnt_q <= '0;
        else if (clr_i)
            cnt_q <= '0;
        else if (en_i)
            cnt_q <= cnt_q + 1'b1;
    end

    // Fires on the strobe that brings the count up to the limit.
    assign expired_o = en_i && (cnt_q == TIMEOUT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/m68k_bus_cycle.sv
// One 68000 asynchronous bus cycle per request, stepping S0..S7 on MC clock strobes.
// Optional S4 watchdog abort is built when BUS_TIMEOUT_EN is defined.
module m68k_bus_cycle
    import m68k_bus_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int TIMEOUT_W      = 8
) (
    input  logic        SYSCLK,
    input  logic        RESET,
    input  logic        MCCLK_RISING,
    input  logic        MCCLK_FALLING,
    input  logic        DTACK_LATCH,
    input  logic        REQ,
    input  logic        REQ_RW,
    input  logic [22:0] REQ_ADDR,
    input  logic [1:0]  REQ_BE,
    input  logic [15:0] REQ_WDATA,
    input  logic [15:0] D_IN,
    output logic        BUSY,
    output logic        DONE,
    output logic        ERR,
    output logic [15:0] RDATA,
    output logic [22:0] A_OUT,
    output logic [15:0] D_OUT,
    output logic        D_OE,
    output logic        AS_N,
    output logic        UDS_N,
    output logic        LDS_N,
    output logic        RW_OUT
);

    if (2 ** TIMEOUT_W <= TIMEOUT_CYCLES) begin : g_width_check
        $error("TIMEOUT_W too narrow for TIMEOUT_CYCLES");
    end

    bus_state_e  state_q;
    logic        busy_q, done_q, err_q, aborted_q, dtack_seen_q;
    logic [15:0] rdata_q, dout_q, cap_wdata_q;
    logic [22:0] a_q, cap_addr_q;
    logic [1:0]  cap_be_q;
    logic        cap_rw_q, doe_q, as_q, uds_q, lds_q, rw_q;

    logic rise, fall, dtack_hit, dtack_arm, to_expired;

    // Simultaneous strobes are treated as a rising edge only.
    assign rise      = MCCLK_RISING;
    assign fall      = MCCLK_FALLING && !MCCLK_RISING;
    assign dtack_hit = dtack_seen_q || DTACK_LATCH;
    assign dtack_arm = DTACK_LATCH && (state_q inside {S2, S3, S4, S5, S6});

`ifdef BUS_TIMEOUT_EN
    logic to_clr, to_en;
    assign to_clr = (state_q == S3) && rise;
    assign to_en  = (state_q == S4) && fall && !dtack_hit;

    m68k_bus_timeout #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
        .TIMEOUT_W     (TIMEOUT_W)
    ) u_timeout (
        .clk_i    (SYSCLK),
        .rst_i    (RESET),
        .clr_i    (to_clr),
        .en_i     (to_en),
        .expired_o(to_expired)
    );
`else
    assign to_expired = 1'b0;
`endif

    always_ff @(negedge SYSCLK or posedge RESET) begin
        if (RESET) begin
            state_q      <= IDLE;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            aborted_q    <= 1'b0;
            dtack_seen_q <= 1'b0;
            rdata_q      <= '0;
            a_q          <= '0;
            dout_q       <= '0;
            doe_q        <= 1'b0;
            as_q         <= STROBE_OFF;
            uds_q        <= STROBE_OFF;
            lds_q        <= STROBE_OFF;
            rw_q         <= RW_READ;
            cap_rw_q     <= RW_READ;
            cap_addr_q   <= '0;
            cap_be_q     <= BE_BOTH;
            cap_wdata_q  <= '0;
        end else begin
            done_q <= 1'b0;
            err_q  <= 1'b0;
            if (dtack_arm)
                dtack_seen_q <= 1'b1;

            unique case (state_q)
                IDLE: if (REQ) begin
                    cap_rw_q    <= REQ_RW;
                    cap_addr_q  <= REQ_ADDR;
                    cap_be_q    <= be_norm(REQ_BE);
                    cap_wdata_q <= REQ_WDATA;
                    busy_q      <= 1'b1;
                    state_q     <= ARMED;
                end
                ARMED: if (rise) begin
                    a_q     <= cap_addr_q;
                    rw_q    <= cap_rw_q;
                    state_q <= S0;
                end
                S0: if (fall) state_q <= S1;
                S1: if (rise) begin
                    as_q <= 1'b0;
                    if (cap_rw_q) begin
                        uds_q <= ~cap_be_q[BE_UDS_BIT];
                        lds_q <= ~cap_be_q[BE_LDS_BIT];
                    end
                    state_q <= S2;
                end
                S2: if (fall) begin
                    if (!cap_rw_q) begin
                        dout_q <= cap_wdata_q;
                        doe_q  <= 1'b1;
                    end
                    state_q <= S3;
                end
                S3: if (rise) begin
                    if (!cap_rw_q) begin
                        uds_q <= ~cap_be_q[BE_UDS_BIT];
                        lds_q <= ~cap_be_q[BE_LDS_BIT];
                    end
                    state_q <= S4;
                end
                S4: begin
                    if (to_expired) begin
                        as_q      <= STROBE_OFF;
                        uds_q     <= STROBE_OFF;
                        lds_q     <= STROBE_OFF;
                        aborted_q <= 1'b1;
                        if (cap_rw_q)
                            rdata_q <= 16'hFFFF;
                        state_q <= S7;
                    end else if (fall && dtack_hit) begin
                        state_q <= S5;
                    end
                end
                S5: if (rise) state_q <= S6;
                S6: if (fall) begin
                    if (cap_rw_q)
                        rdata_q <= D_IN;
                    as_q    <= STROBE_OFF;
                    uds_q   <= STROBE_OFF;
                    lds_q   <= STROBE_OFF;
                    state_q <= S7;
                end
                S7: if (rise) begin
                    doe_q        <= 1'b0;
                    rw_q         <= RW_READ;
                    dtack_seen_q <= 1'b0;
                    busy_q       <= 1'b0;
                    done_q       <= 1'b1;
                    err_q        <= aborted_q;
                    aborted_q    <= 1'b0;
                    state_q      <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign BUSY   = busy_q;
    assign DONE   = done_q;
    assign ERR    = err_q;
    assign RDATA  = rdata_q;
    assign A_OUT  = a_q;
    assign D_OUT  = dout_q;
    assign D_OE   = doe_q;
    assign AS_N   = as_q;
    assign UDS_N  = uds_q;
    assign LDS_N  = lds_q;
    assign RW_OUT = rw_q;

endmodule

// File: tb/tb_m68k_bus_cycle.sv
// Self-checking bench for m68k_bus_cycle; expected pins derived from MC edge counts.
// Define BUS_TIMEOUT_EN for both bench and RTL to exercise the watchdog abort.
module tb_m68k_bus_cycle;

    localparam int TO = 4;

    logic        SYSCLK = 1'b0;
    logic        RESET, MCCLK_RISING, MCCLK_FALLING, DTACK_LATCH, REQ, REQ_RW;
    logic [22:0] REQ_ADDR;
    logic [1:0]  REQ_BE;
    logic [15:0] REQ_WDATA, D_IN;
    logic        BUSY, DONE, ERR, D_OE, AS_N, UDS_N, LDS_N, RW_OUT;
    logic [15:0] RDATA, D_OUT;
    logic [22:0] A_OUT;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] rdata_exp;

    always #5 SYSCLK = ~SYSCLK;

    m68k_bus_cycle #(.TIMEOUT_CYCLES(TO), .TIMEOUT_W(4)) dut (
        .SYSCLK(SYSCLK), .RESET(RESET), .MCCLK_RISING(MCCLK_RISING),
        .MCCLK_FALLING(MCCLK_FALLING), .DTACK_LATCH(DTACK_LATCH), .REQ(REQ),
        .REQ_RW(REQ_RW), .REQ_ADDR(REQ_ADDR), .REQ_BE(REQ_BE), .REQ_WDATA(REQ_WDATA),
        .D_IN(D_IN), .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .RDATA(RDATA),
        .A_OUT(A_OUT), .D_OUT(D_OUT), .D_OE(D_OE), .AS_N(AS_N), .UDS_N(UDS_N),
        .LDS_N(LDS_N), .RW_OUT(RW_OUT)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(negedge SYSCLK);
        @(posedge SYSCLK);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, ".busy"}, 32'(BUSY), 32'(0));
        chk({tag, ".done"}, 32'(DONE), 32'(0));
        chk({tag, ".err"},  32'(ERR), 32'(0));
        chk({tag, ".rdata"}, 32'(RDATA), 32'(0));
        chk({tag, ".a"},    32'(A_OUT), 32'(0));
        chk({tag, ".d"},    32'(D_OUT), 32'(0));
        chk({tag, ".oe"},   32'(D_OE), 32'(0));
        chk({tag, ".as"},   32'(AS_N), 32'(1));
        chk({tag, ".uds"},  32'(UDS_N), 32'(1));
        chk({tag, ".lds"},  32'(LDS_N), 32'(1));
        chk({tag, ".rw"},   32'(RW_OUT), 32'(1));
    endtask

    task automatic do_reset(input string tag);
        #1 RESET = 1'b1;
        #1 chk_reset(tag);
        #1 RESET = 1'b0;
        rdata_exp = '0;
    endtask

    // Pin picture after the k-th MC edge since S0; rel is the edge that releases the strobes.
    task automatic chk_pins(input string tag, input int k, input bit rw, input logic [1:0] be,
                            input int rel, input logic [22:0] addr, input logic [15:0] wd);
        bit strb;
        string t;
        t = $sformatf("%s@%0d", tag, k);
        strb = (k < rel) && (k >= (rw ? 2 : 4));
        chk({t, ".as"},   32'(AS_N),   32'(!(k >= 2 && k < rel)));
        chk({t, ".uds"},  32'(UDS_N),  32'(!(strb && be[1])));
        chk({t, ".lds"},  32'(LDS_N),  32'(!(strb && be[0])));
        chk({t, ".oe"},   32'(D_OE),   32'(!rw && k >= 3 && k <= rel));
        chk({t, ".rw"},   32'(RW_OUT), 32'(rw || k > rel));
        chk({t, ".busy"}, 32'(BUSY),   32'(k <= rel));
        chk({t, ".done"}, 32'(DONE),   32'(k == rel + 1));
        chk({t, ".a"},    32'(A_OUT),  32'(addr));
        if (!rw && k >= 3)
            chk({t, ".d"}, 32'(D_OUT), 32'(wd));
    endtask

    // dt1/dt2: DTACK pulse in the cycle after that MC edge index (<2 means S0/S1, ignored).
    task automatic run_txn(input string tag, input bit rw, input logic [22:0] addr,
                           input logic [1:0] be, input logic [15:0] wd, input logic [15:0] din,
                           input int dt1, input int dt2, input bit idle_dt, input bit hold_req,
                           input int rst_edge, input bit both_inj);
        int eff, w, rel, n;
        bit tmo;
        logic [1:0] ben;
        ben = (be == 2'b00) ? 2'b11 : be;
        eff = 1000;
        if (dt1 >= 2 && dt1 < eff) eff = dt1;
        if (dt2 >= 2 && dt2 < eff) eff = dt2;
        // Each full MC period of waiting in S4 adds two edges.
        w   = (eff <= 4) ? 0 : (eff - 3) / 2;
        tmo = 1'b0;
        rel = 7 + 2 * w;
`ifdef BUS_TIMEOUT_EN
        if (w >= TO) begin
            tmo = 1'b1;
            rel = 5 + 2 * (TO - 1);
        end
`endif
        D_IN = ~din;
        if (idle_dt) begin
            DTACK_LATCH = 1'b1;
            step();
            DTACK_LATCH = 1'b0;
            chk({tag, ".idle_busy"}, 32'(BUSY), 32'(0));
        end
        REQ = 1'b1; REQ_RW = rw; REQ_ADDR = addr; REQ_BE = be; REQ_WDATA = wd;
        MCCLK_RISING = 1'($urandom_range(0, 1));
        step();
        MCCLK_RISING = 1'b0;
        chk({tag, ".acc_busy"}, 32'(BUSY), 32'(1));
        chk({tag, ".acc_as"},   32'(AS_N), 32'(1));
        REQ = hold_req;
        REQ_RW = 1'($urandom); REQ_ADDR = 23'($urandom);
        REQ_BE = 2'($urandom); REQ_WDATA = 16'($urandom);
        n = $urandom_range(1, 2);
        repeat (n) begin
            step();
            chk({tag, ".armed_busy"}, 32'(BUSY), 32'(1));
            chk({tag, ".armed_as"},   32'(AS_N), 32'(1));
        end
        for (int k = 0; k <= rel + 1; k++) begin
            if (both_inj && k == 1) begin
                MCCLK_RISING = 1'b1; MCCLK_FALLING = 1'b1;
                step();
                MCCLK_RISING = 1'b0; MCCLK_FALLING = 1'b0;
                chk_pins({tag, ".both"}, 0, rw, ben, rel, addr, wd);
                step();
            end
            D_IN = (k == rel) ? din : ~din;
            if (k % 2 == 0) MCCLK_RISING = 1'b1;
            else            MCCLK_FALLING = 1'b1;
            step();
            MCCLK_RISING = 1'b0; MCCLK_FALLING = 1'b0;
            chk_pins(tag, k, rw, ben, rel, addr, wd);
            if (k == rst_edge) begin
                do_reset({tag, ".midrst"});
                for (int i = 0; i < 6; i++) begin
                    MCCLK_RISING = (i % 2 == 0); MCCLK_FALLING = (i % 2 == 1);
                    step();
                    MCCLK_RISING = 1'b0; MCCLK_FALLING = 1'b0;
                    chk({tag, ".post_busy"}, 32'(BUSY), 32'(0));
                    chk({tag, ".post_done"}, 32'(DONE), 32'(0));
                    chk({tag, ".post_as"},   32'(AS_N), 32'(1));
                end
                return;
            end
            if (k == rel + 1) begin
                if (rw) rdata_exp = tmo ? 16'hFFFF : din;
                chk({tag, ".err"},   32'(ERR),   32'(tmo));
                chk({tag, ".rdata"}, 32'(RDATA), 32'(rdata_exp));
            end else begin
                n = $urandom_range(1, 2);
                for (int g = 0; g < n; g++) begin
                    if (g == 0 && (k == dt1 || k == dt2)) DTACK_LATCH = 1'b1;
                    step();
                    DTACK_LATCH = 1'b0;
                    chk_pins(tag, k, rw, ben, rel, addr, wd);
                end
            end
        end
        step();
        if (hold_req) begin
            chk({tag, ".reaccept"}, 32'(BUSY), 32'(1));
            REQ = 1'b0;
            do_reset({tag, ".cleanup"});
            step();
        end else begin
            chk({tag, ".end_busy"},  32'(BUSY),  32'(0));
            chk({tag, ".end_done"},  32'(DONE),  32'(0));
            chk({tag, ".end_rdata"}, 32'(RDATA), 32'(rdata_exp));
        end
    endtask

    initial begin
        RESET = 1'b1; MCCLK_RISING = 1'b0; MCCLK_FALLING = 1'b0; DTACK_LATCH = 1'b0;
        REQ = 1'b0; REQ_RW = 1'b1; REQ_ADDR = '0; REQ_BE = '0; REQ_WDATA = '0; D_IN = '0;
        rdata_exp = '0;
        step();
        step();
        chk_reset("reset");
        #1 RESET = 1'b0;
        step();

        run_txn("rd",    1'b1, 23'h000100, 2'b11, 16'h0000, 16'hA55A, 3, -1, 1'b0, 1'b0, -1, 1'b0);
        run_txn("wr",    1'b0, 23'h0ABCDE, 2'b10, 16'h1234, 16'h0000, 4, -1, 1'b0, 1'b0, -1, 1'b0);
        run_txn("rst",   1'b1, 23'h012345, 2'b11, 16'h0000, 16'hBEEF, 2, -1, 1'b0, 1'b0,  5, 1'b0);
        run_txn("wait3", 1'b1, 23'h7FFFFF, 2'b01, 16'h0000, 16'h5AA5, 9, -1, 1'b0, 1'b0, -1, 1'b0);
        run_txn("ign",   1'b0, 23'h000001, 2'b11, 16'hCAFE, 16'h0000, 1,  8, 1'b1, 1'b0, -1, 1'b0);
        run_txn("both",  1'b1, 23'h2AAAAA, 2'b00, 16'h0000, 16'h0F0F, 4, -1, 1'b0, 1'b0, -1, 1'b1);
        run_txn("be00",  1'b0, 23'h155555, 2'b00, 16'h8001, 16'h0000, 6, -1, 1'b0, 1'b0, -1, 1'b0);
`ifdef BUS_TIMEOUT_EN
        run_txn("tmo",   1'b1, 23'h000200, 2'b11, 16'h0000, 16'h1357, 1, -1, 1'b0, 1'b0, -1, 1'b0);
        run_txn("tmo_w", 1'b0, 23'h000300, 2'b10, 16'h2468, 16'h0000, 0, -1, 1'b0, 1'b0, -1, 1'b0);
`endif
        run_txn("hold",  1'b0, 23'h00FACE, 2'b11, 16'h4321, 16'h0000, 3, -1, 1'b0, 1'b1, -1, 1'b0);
        for (int i = 0; i < 10; i++)
            run_txn("rnd", 1'($urandom), 23'($urandom), 2'($urandom), 16'($urandom), 16'($urandom),
                    int'($urandom_range(2, 10)), int'($urandom_range(0, 10)),
                    1'($urandom), 1'b0, -1, 1'($urandom));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
